nand_gate: RTL and testbench



---
 rtl/nand_gate_if.sv | 26 ++
 rtl/nand_gate.sv | 43 ++++
 tb/tb_nand_gate.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nand_gate_if.sv
// Operand/result bundle for the registered NAND primitive.
interface nand_gate_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] y;
  logic             out_valid;

  modport master (
    output a,
    output b,
    output in_valid,
    input  y,
    input  out_valid
  );

  modport slave (
    input  a,
    input  b,
    input  in_valid,
    output y,
    output out_valid
  );
endinterface

// File: rtl/nand_gate.sv
// Registered bitwise NAND with a LATENCY-deep valid-qualified pipeline.
// Data registers only load on a qualified sample, so y holds through bubbles.
module nand_gate #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  nand_gate_if.slave  bus
);

  logic [WIDTH-1:0]   data_q [LATENCY];
  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   nand_c;

  // NAND evaluated ahead of the first stage
  assign nand_c = ~(bus.a & bus.b);

  // Pipeline: valids shift every cycle, data advances only behind a valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data_q[i] <= '1;
      end
    end else begin
      valid_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        data_q[0] <= nand_c;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign bus.y         = data_q[LATENCY-1];
  assign bus.out_valid = valid_q[LATENCY-1];

endmodule

// File: tb/tb_nand_gate.sv
// Bench for nand_gate: four configurations, directed and randomized checks
// against a history-based reference model.
module tb_nand_gate;

  localparam int NI = 4;
  localparam int W_T   [NI] = '{1, 8, 8, 4};
  localparam int LAT_T [NI] = '{1, 3, 4, 2};

  logic clk;
  logic rst_n;

  logic [7:0] a_s  [NI];
  logic [7:0] b_s  [NI];
  logic       v_s  [NI];
  logic [7:0] y_s  [NI];
  logic       ov_s [NI];

  int n_tests;
  int n_fail;

  // Stimulus log and observed outputs for the generic driver
  logic [7:0] sa [64];
  logic [7:0] sb [64];
  logic       sv [64];
  logic [7:0] obs_y [80];
  logic       obs_v [80];

  nand_gate_if #(.WIDTH(1)) if0 ();
  nand_gate_if #(.WIDTH(8)) if1 ();
  nand_gate_if #(.WIDTH(8)) if2 ();
  nand_gate_if #(.WIDTH(4)) if3 ();

  nand_gate #(.WIDTH(1), .LATENCY(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  nand_gate #(.WIDTH(8), .LATENCY(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  nand_gate #(.WIDTH(8), .LATENCY(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  nand_gate #(.WIDTH(4), .LATENCY(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  assign if0.a = a_s[0][0:0];
  assign if0.b = b_s[0][0:0];
  assign if0.in_valid = v_s[0];
  assign if1.a = a_s[1];
  assign if1.b = b_s[1];
  assign if1.in_valid = v_s[1];
  assign if2.a = a_s[2];
  assign if2.b = b_s[2];
  assign if2.in_valid = v_s[2];
  assign if3.a = a_s[3][3:0];
  assign if3.b = b_s[3][3:0];
  assign if3.in_valid = v_s[3];

  assign y_s[0] = 8'(if0.y);
  assign y_s[1] = if1.y;
  assign y_s[2] = if2.y;
  assign y_s[3] = 8'(if3.y);
  assign ov_s[0] = if0.out_valid;
  assign ov_s[1] = if1.out_valid;
  assign ov_s[2] = if2.out_valid;
  assign ov_s[3] = if3.out_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mask_of(input int k);
    logic [8:0] m;
    m = (9'd1 << W_T[k]) - 9'd1;
    return m[7:0];
  endfunction

  // Reference: output at observation j reflects the sample logged L slots
  // earlier; y is the NAND of the newest valid sample at or before then,
  // all-ones if none since reset.
  function automatic void model_at(input int k, input int j, input int n,
                                   output logic ev, output logic [7:0] ey);
    int src;
    src = j - LAT_T[k];
    ev  = (src >= 0 && src < n) ? sv[src] : 1'b0;
    ey  = mask_of(k);
    for (int i = 0; i <= src && i < n; i++) begin
      if (sv[i]) ey = ~(sa[i] & sb[i]) & mask_of(k);
    end
  endfunction

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
      v_s[k] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive n logged samples into instance k, recording outputs each cycle
  task automatic run_stim(input int k, input int n, input int cycles);
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      obs_y[j] = y_s[k];
      obs_v[j] = ov_s[k];
      if (j < n) begin
        a_s[k] = sa[j];
        b_s[k] = sb[j];
        v_s[k] = sv[j];
      end else begin
        a_s[k] = '0;
        b_s[k] = '0;
        v_s[k] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_all();
    rst_n  = 1'b0;
    a_s[0] = 8'h01;
    b_s[0] = 8'h01;
    v_s[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        n_tests++;
        if (y_s[k] !== mask_of(k) || ov_s[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_hold inst%0d cyc%0d: y=%h ov=%b, want y=%h ov=0",
                   k, c, y_s[k], ov_s[k], mask_of(k));
        end
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (y_s[0] !== 8'h00 || ov_s[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: y=%h ov=%b, want y=00 ov=1", y_s[0], ov_s[0]);
    end
    v_s[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (y_s[0] !== 8'h00 || ov_s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_pulse: y=%h ov=%b, want y=00 ov=0", y_s[0], ov_s[0]);
    end
  endtask

  task automatic test_truth_table();
    logic [7:0] want_y [4];
    want_y = '{8'h01, 8'h01, 8'h01, 8'h00};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      sa[i] = 8'(i >> 1);
      sb[i] = 8'(i & 1);
      sv[i] = 1'b1;
    end
    run_stim(0, 4, 6);
    for (int j = 1; j <= 4; j++) begin
      n_tests++;
      if (obs_y[j] !== want_y[j-1] || obs_v[j] !== 1'b1) begin
        n_fail++;
        $display("FAIL truth_table row%0d: y=%h ov=%b, want y=%h ov=1",
                 j - 1, obs_y[j], obs_v[j], want_y[j-1]);
      end
    end
    n_tests++;
    if (obs_v[5] !== 1'b0 || obs_y[5] !== 8'h00) begin
      n_fail++;
      $display("FAIL truth_table_tail: y=%h ov=%b, want y=00 ov=0", obs_y[5], obs_v[5]);
    end
  endtask

  task automatic test_latency3();
    logic       ev;
    logic [7:0] ey;
    apply_reset();
    sa[0] = 8'hF0;
    sb[0] = 8'hCC;
    sv[0] = 1'b1;
    run_stim(1, 1, 6);
    for (int j = 0; j < 6; j++) begin
      ev = (j == 3);
      ey = (j >= 3) ? 8'h3F : 8'hFF;
      n_tests++;
      if (obs_y[j] !== ey || obs_v[j] !== ev) begin
        n_fail++;
        $display("FAIL latency3 cyc%0d: y=%h ov=%b, want y=%h ov=%b",
                 j, obs_y[j], obs_v[j], ey, ev);
      end
    end
  endtask

  task automatic test_bubble();
    logic want_v [4];
    want_v = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    sa[0] = 8'h01; sb[0] = 8'h01; sv[0] = 1'b1;
    sa[1] = 8'h00; sb[1] = 8'h00; sv[1] = 1'b0;
    run_stim(0, 2, 4);
    for (int j = 1; j < 4; j++) begin
      n_tests++;
      if (obs_y[j] !== 8'h00 || obs_v[j] !== want_v[j]) begin
        n_fail++;
        $display("FAIL bubble_hold cyc%0d: y=%h ov=%b, want y=00 ov=%b",
                 j, obs_y[j], obs_v[j], want_v[j]);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      a_s[2] = 8'($urandom);
      b_s[2] = 8'($urandom);
      v_s[2] = 1'b1;
    end
    @(negedge clk);
    v_s[2] = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      n_tests++;
      if (y_s[2] !== 8'hFF || ov_s[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset cyc%0d: y=%h ov=%b, want y=ff ov=0",
                 c, y_s[2], ov_s[2]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_streaming();
    logic       ev;
    logic [7:0] ey;
    int         ov_count;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      sa[i] = 8'($urandom) & 8'h0F;
      sb[i] = 8'($urandom) & 8'h0F;
      sv[i] = 1'b1;
    end
    run_stim(3, 16, 20);
    ov_count = 0;
    for (int j = 0; j < 20; j++) begin
      model_at(3, j, 16, ev, ey);
      if (obs_v[j] === 1'b1) ov_count++;
      n_tests++;
      if (obs_y[j] !== ey || obs_v[j] !== ev) begin
        n_fail++;
        $display("FAIL streaming cyc%0d: y=%h ov=%b, want y=%h ov=%b",
                 j, obs_y[j], obs_v[j], ey, ev);
      end
    end
    n_tests++;
    if (ov_count != 16 || obs_v[2] !== 1'b1 || obs_v[17] !== 1'b1) begin
      n_fail++;
      $display("FAIL streaming_run: ov_count=%0d first=%b last=%b, want 16 contiguous",
               ov_count, obs_v[2], obs_v[17]);
    end
  endtask

  task automatic test_random();
    logic       ev;
    logic [7:0] ey;
    for (int k = 0; k < NI; k++) begin
      apply_reset();
      for (int i = 0; i < 40; i++) begin
        sa[i] = 8'($urandom) & mask_of(k);
        sb[i] = 8'($urandom) & mask_of(k);
        sv[i] = ($urandom_range(0, 2) != 0);
      end
      run_stim(k, 40, 46);
      for (int j = 0; j < 46; j++) begin
        model_at(k, j, 40, ev, ey);
        n_tests++;
        if (obs_y[j] !== ey || obs_v[j] !== ev) begin
          n_fail++;
          $display("FAIL random inst%0d cyc%0d: y=%h ov=%b, want y=%h ov=%b",
                   k, j, obs_y[j], obs_v[j], ey, ev);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    test_reset();
    test_truth_table();
    test_latency3();
    test_bubble();
    test_mid_reset();
    test_streaming();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
